// File: rtl/add_serial_pkg.sv
// ----------------------------------------------------------------------------
// add_serial_pkg
// Shared definitions for the round-robin bit-serial adder scheduler.
//   DEF_NREQ      : default number of requesters
//   DEF_WIDTH     : default operand / sum width
//   sched_state_e : scheduler state encoding (IDLE=0, ADD=1, RESP=2)
// ----------------------------------------------------------------------------
package add_serial_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } sched_state_e;

endpackage

// File: rtl/serial_add_core.sv
// ----------------------------------------------------------------------------
// serial_add_core
// LSB-first bit-serial adder datapath: operand shift registers, partial sum
// shift register and carry flop. Sequencing comes from the instantiating
// scheduler. This block has no FSM.
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset (clears all registers)
//   clr        : synchronous clear, same effect as rst
//   load       : capture a_load/b_load, zero the sum and carry
//   shift      : perform one add bit and shift everything right by one
//   a_load     : operand A to load
//   b_load     : operand B to load
//   sum_next   : sum register value after the current shift
//   carry_next : carry after the current bit (majority of a[0], b[0], c)
// ----------------------------------------------------------------------------
module serial_add_core
  import add_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a_load,
  input  logic [WIDTH-1:0] b_load,
  output logic [WIDTH-1:0] sum_next,
  output logic             carry_next
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             bit_sum;

  assign bit_sum    = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) |
                      (b_reg[0] & carry_reg);
  // Each new sum bit enters at the MSB so that after WIDTH shifts the first
  // (LSB) result bit has travelled down to bit 0.
  assign sum_next   = {bit_sum, sum_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else if (load) begin
      a_reg     <= a_load;
      b_reg     <= b_load;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else if (shift) begin
      a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
      b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
    end
  end

endmodule

// File: rtl/add_serial_sched.sv
// ----------------------------------------------------------------------------
// add_serial_sched
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
// Per job: grant one requester, load its operands, run WIDTH LSB-first add
// cycles, then hold the result on a valid/ready response port.
// Optional build macro: ADD_SERIAL_SCHED_SAT_EN -- when defined, a final
// carry of 1 saturates rsp_sum to all-ones (rsp_cout still shows the carry).
// Ports:
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-high reset
//   req       : per-requester request levels
//   a_in/b_in : operands, requester i at [i*WIDTH +: WIDTH]
//   gnt       : one-hot grant pulse on the accept cycle
//   busy      : high whenever not IDLE
//   rsp_valid : result valid
//   rsp_ready : consumer accepts result
//   rsp_id    : requester owning the result
//   rsp_sum   : sum (mod 2^WIDTH, or saturated with the macro)
//   rsp_cout  : carry out of the MSB
// ----------------------------------------------------------------------------
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ADD  = ADD;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]       state_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [CNTW-1:0]  count_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic             rsp_valid_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic [WIDTH-1:0] rsp_sum_reg;
  logic             rsp_cout_reg;

  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   ptr_next;
  logic             last_bit;
  logic             bad_state;
  logic             core_load;
  logic             core_shift;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] sum_final;
  logic             carry_next;

  // Operand slices per requester.
  logic [WIDTH-1:0] a_sl [NREQ];
  logic [WIDTH-1:0] b_sl [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_sl[gi] = a_in[gi*WIDTH +: WIDTH];
      assign b_sl[gi] = b_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick: scan offsets from the highest down so the smallest
  // offset from ptr (the first requester at or after ptr) ends up winning.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr_reg) + k) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'((int'(ptr_reg) + k) % NREQ);
      end
    end
  end

  assign ptr_next   = IDW'((int'(pick_idx) + 1) % NREQ);
  assign last_bit   = (count_reg == CNTW'(WIDTH - 1));
  assign bad_state  = (state_reg != ST_IDLE) && (state_reg != ST_ADD) &&
                      (state_reg != ST_RESP);
  assign core_load  = (state_reg == ST_IDLE) && pick_valid;
  assign core_shift = (state_reg == ST_ADD);

`ifdef ADD_SERIAL_SCHED_SAT_EN
  assign sum_final = carry_next ? {WIDTH{1'b1}} : sum_next;
`else
  assign sum_final = sum_next;
`endif

  serial_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .clr        (bad_state),
    .load       (core_load),
    .shift      (core_shift),
    .a_load     (a_sl[pick_idx]),
    .b_load     (b_sl[pick_idx]),
    .sum_next   (sum_next),
    .carry_next (carry_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      count_reg     <= '0;
      gnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_sum_reg   <= '0;
      rsp_cout_reg  <= 1'b0;
    end else begin
      gnt_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_reg    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            rsp_id_reg <= pick_idx;
            count_reg  <= '0;
            ptr_reg    <= ptr_next;
            state_reg  <= ST_ADD;
          end
        end
        ST_ADD: begin
          count_reg <= count_reg + 1'b1;
          if (last_bit) begin
            rsp_sum_reg   <= sum_final;
            rsp_cout_reg  <= carry_next;
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encoding: recover to IDLE with reset outputs.
          state_reg     <= ST_IDLE;
          ptr_reg       <= '0;
          count_reg     <= '0;
          rsp_valid_reg <= 1'b0;
          rsp_id_reg    <= '0;
          rsp_sum_reg   <= '0;
          rsp_cout_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign busy      = (state_reg == ST_ADD) || (state_reg == ST_RESP);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_cout  = rsp_cout_reg;

endmodule
